fetch_seq: RTL and testbench

Parametrised successor to the first-generation program-counter fetch unit. It holds the program counter and produces the next instruction address every cycle. Beyond sequential/branch/start sequencing it adds a run/halt state machine, a fetch stall, and a small return-address stack for call/return. It sits between control/branch-resolution logic and instruction memory; `pc` drives the instruction memory address directly.

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_ras.sv | 46 ++++
 rtl/fetch_seq.sv | 108 ++++++++++
 tb/tb_fetch_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types, default widths and address arithmetic for the fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_t;

  localparam int PC_WIDTH_DEF     = 7;
  localparam int OFFSET_WIDTH_DEF = 5;
  localparam int RAS_DEPTH_DEF    = 4;

  // Sign-extends the low off_w bits of off and adds them to pc; the caller
  // keeps only its own PC width, which gives the modulo-2^PC_WIDTH wrap.
  function automatic logic [63:0] sext_add(input logic [63:0] pc,
                                           input logic [63:0] off,
                                           input int          off_w);
    logic [63:0] s;
    s = off << (64 - off_w);
    s = $signed(s) >>> (64 - off_w);
    return pc + s;
  endfunction

endpackage

// File: rtl/fetch_ras.sv
// Return-address stack: LIFO with an occupancy count running 0..RAS_DEPTH.
module fetch_ras #(
  parameter int PC_WIDTH  = 7,
  parameter int RAS_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] din,
  output logic [PC_WIDTH-1:0] dout,
  output logic                full,
  output logic                empty
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       wr_idx, rd_idx;

  assign wr_idx = AW'(cnt_q);
  assign rd_idx = AW'(cnt_q - CW'(1));
  assign full   = (cnt_q == CW'(RAS_DEPTH));
  assign empty  = (cnt_q == '0);
  assign dout   = mem_q[rd_idx];

  always_comb begin
    cnt_d = cnt_q;
    if (clear)               cnt_d = '0;
    else if (push && !full)  cnt_d = cnt_q + CW'(1);
    else if (pop && !empty)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Entries are only meaningful below the count, so the array needs no reset.
  always_ff @(posedge clock) begin
    if (push && !full && !clear) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/fetch_seq.sv
// Program-counter fetch sequencer: run/halt FSM, stall, branch, call/return.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int RAS_DEPTH    = RAS_DEPTH_DEF
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [PC_WIDTH-1:0]            start_address,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           taken,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           halt,
  input  logic signed [OFFSET_WIDTH-1:0] offset,
  output logic [PC_WIDTH-1:0]            pc,
  output logic                           valid,
  output logic                           done,
  output logic                           ras_err
);
  fetch_state_t        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, done_q, err_q, err_d;
  logic                ras_push, ras_pop, ras_clear, ras_full, ras_empty;
  logic [PC_WIDTH-1:0] ras_dout, pc_inc, pc_tgt;
  logic [63:0]         tgt_w;
  logic [63-PC_WIDTH:0] unused_hi;

  assign tgt_w     = sext_add({{(64-PC_WIDTH){1'b0}}, pc_q},
                              {{(64-OFFSET_WIDTH){1'b0}}, offset}, OFFSET_WIDTH);
  assign pc_tgt    = tgt_w[PC_WIDTH-1:0];
  assign unused_hi = tgt_w[63:PC_WIDTH];
  assign pc_inc    = pc_q + PC_WIDTH'(1);

  fetch_ras #(.PC_WIDTH(PC_WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (ras_push),
    .pop     (ras_pop),
    .clear   (ras_clear),
    .din     (pc_inc),
    .dout    (ras_dout),
    .full    (ras_full),
    .empty   (ras_empty)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = err_q;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_clear = 1'b0;
    if (start) begin
      // start behaves identically from every state and wipes call history
      state_d   = ST_RUN;
      pc_d      = start_address;
      ras_clear = 1'b1;
      err_d     = 1'b0;
    end else if (state_q == ST_RUN && !stall) begin
      if (halt) begin
        state_d = ST_HALTED;
      end else if (ret) begin
        if (!ras_empty) begin
          ras_pop = 1'b1;
          pc_d    = ras_dout;
        end else begin
          pc_d  = pc_inc;
          err_d = 1'b1;
        end
      end else if (call) begin
        ras_push = !ras_full;
        err_d    = err_q | ras_full;
        pc_d     = pc_tgt;
      end else if (branch && taken) begin
        pc_d = pc_tgt;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_HALTED);
      err_q   <= err_d;
    end
  end

  assign pc      = pc_q;
  assign valid   = valid_q;
  assign done    = done_q;
  assign ras_err = err_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq: directed scenarios plus randomized run vs. a queue-based model.
module tb_fetch_seq;
  logic             clock = 1'b0;
  logic             reset_n, start, stall, branch, taken, call, ret, halt;
  logic [6:0]       start_address;
  logic signed [4:0] offset;
  logic [6:0]       pc;
  logic             valid, done, ras_err;

  int total = 0;
  int bad   = 0;

  // reference model: 0 idle, 1 run, 2 halted
  int m_st = 0;
  int m_pc = 0;
  int m_err = 0;
  int m_stk[$];

  fetch_seq dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .stall(stall), .branch(branch), .taken(taken), .call(call), .ret(ret),
    .halt(halt), .offset(offset), .pc(pc), .valid(valid), .done(done),
    .ras_err(ras_err)
  );

  always #5 clock = ~clock;

  task automatic clr_in();
    reset_n = 1'b1; start = 1'b0; start_address = '0; stall = 1'b0;
    branch = 1'b0; taken = 1'b0; call = 1'b0; ret = 1'b0; halt = 1'b0; offset = '0;
  endtask

  // Advance one edge and update the model from the spec's rules.
  task automatic tick();
    int o;
    @(posedge clock);
    o = offset;
    if (!reset_n) begin
      m_st = 0; m_pc = 0; m_err = 0; m_stk.delete();
    end else if (start) begin
      m_st = 1; m_pc = start_address; m_err = 0; m_stk.delete();
    end else if (m_st == 1 && !stall) begin
      if (halt) m_st = 2;
      else if (ret) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % 128; m_err = 1; end
      end else if (call) begin
        if (m_stk.size() < 4) m_stk.push_back((m_pc + 1) % 128);
        else m_err = 1;
        m_pc = (m_pc + o) & 127;
      end else if (branch && taken) m_pc = (m_pc + o) & 127;
      else m_pc = (m_pc + 1) % 128;
    end
    #1;
  endtask

  task automatic go(input int addr);
    clr_in(); start = 1'b1; start_address = 7'(addr); tick(); clr_in();
  endtask

  task automatic test_reset();
    clr_in(); reset_n = 1'b0; tick(); tick(); clr_in();
    total++; if (pc !== 7'd0) begin bad++; $display("FAIL reset_pc got=%0d exp=0", pc); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (ras_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", ras_err); end
    branch = 1'b1; taken = 1'b1; offset = 5'sd3; tick(); clr_in();
    total++; if (pc !== 7'd0 || valid !== 1'b0) begin bad++; $display("FAIL idle_ignore got pc=%0d v=%b exp pc=0 v=0", pc, valid); end
  endtask

  task automatic test_sequential();
    go(10);
    total++; if (pc !== 7'd10 || valid !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL start got pc=%0d v=%b d=%b exp 10/1/0", pc, valid, done); end
    tick();
    total++; if (pc !== 7'd11) begin bad++; $display("FAIL seq1 got=%0d exp=11", pc); end
    tick();
    total++; if (pc !== 7'd12 || valid !== 1'b1) begin bad++; $display("FAIL seq2 got pc=%0d v=%b exp 12/1", pc, valid); end
  endtask

  task automatic test_branch();
    go(20); branch = 1'b1; taken = 1'b1; offset = -5'sd3; tick(); clr_in();
    total++; if (pc !== 7'd17) begin bad++; $display("FAIL br_taken got=%0d exp=17", pc); end
    go(20); branch = 1'b1; taken = 1'b0; offset = -5'sd3; tick(); clr_in();
    total++; if (pc !== 7'd21) begin bad++; $display("FAIL br_not_taken got=%0d exp=21", pc); end
  endtask

  task automatic test_wrap();
    go(127); tick();
    total++; if (pc !== 7'd0) begin bad++; $display("FAIL wrap_inc got=%0d exp=0", pc); end
    go(2); branch = 1'b1; taken = 1'b1; offset = -5'sd5; tick(); clr_in();
    total++; if (pc !== 7'd125) begin bad++; $display("FAIL wrap_neg got=%0d exp=125", pc); end
  endtask

  task automatic test_call_ret();
    go(30); call = 1'b1; offset = 5'sd8; tick(); clr_in();
    total++; if (pc !== 7'd38 || ras_err !== 1'b0) begin bad++; $display("FAIL call got pc=%0d e=%b exp 38/0", pc, ras_err); end
    tick();
    total++; if (pc !== 7'd39) begin bad++; $display("FAIL after_call got=%0d exp=39", pc); end
    ret = 1'b1; call = 1'b1; offset = 5'sd4; tick(); clr_in();
    total++; if (pc !== 7'd31 || ras_err !== 1'b0) begin bad++; $display("FAIL ret got pc=%0d e=%b exp 31/0", pc, ras_err); end
  endtask

  task automatic test_overflow();
    go(0);
    for (int i = 1; i <= 4; i++) begin
      call = 1'b1; offset = 5'sd1; tick(); clr_in();
      total++; if (pc !== 7'(i) || ras_err !== 1'b0) begin bad++; $display("FAIL nest%0d got pc=%0d e=%b exp %0d/0", i, pc, ras_err, i); end
    end
    call = 1'b1; offset = 5'sd1; tick(); clr_in();
    total++; if (pc !== 7'd5 || ras_err !== 1'b1) begin bad++; $display("FAIL overflow got pc=%0d e=%b exp 5/1", pc, ras_err); end
    ret = 1'b1; tick(); clr_in();
    total++; if (pc !== 7'd4 || ras_err !== 1'b1) begin bad++; $display("FAIL ret_after_ovf got pc=%0d e=%b exp 4/1", pc, ras_err); end
  endtask

  task automatic test_underflow();
    go(50); ret = 1'b1; tick(); clr_in();
    total++; if (pc !== 7'd51 || ras_err !== 1'b1) begin bad++; $display("FAIL underflow got pc=%0d e=%b exp 51/1", pc, ras_err); end
    tick();
    total++; if (ras_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", ras_err); end
    go(60);
    total++; if (ras_err !== 1'b0) begin bad++; $display("FAIL err_start_clr got=%b exp=0", ras_err); end
  endtask

  task automatic test_stall_halt();
    go(40);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; branch = 1'b1; taken = 1'b1; call = 1'b1; offset = 5'sd7; tick();
      total++; if (pc !== 7'd40 || valid !== 1'b1) begin bad++; $display("FAIL stall%0d got pc=%0d v=%b exp 40/1", i, pc, valid); end
    end
    clr_in(); halt = 1'b1; tick(); clr_in();
    total++; if (pc !== 7'd40 || valid !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL halt got pc=%0d v=%b d=%b exp 40/0/1", pc, valid, done); end
    branch = 1'b1; taken = 1'b1; offset = 5'sd2; tick(); clr_in();
    total++; if (pc !== 7'd40 || done !== 1'b1) begin bad++; $display("FAIL halted_ignore got pc=%0d d=%b exp 40/1", pc, done); end
    go(5);
    total++; if (pc !== 7'd5 || valid !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL restart got pc=%0d v=%b d=%b exp 5/1/0", pc, valid, done); end
  endtask

  task automatic test_reset_mid();
    go(60); call = 1'b1; offset = 5'sd3; tick(); clr_in();
    ret = 1'b1; tick(); tick(); clr_in();
    total++; if (pc !== 7'd62 || ras_err !== 1'b1) begin bad++; $display("FAIL pre_reset got pc=%0d e=%b exp 62/1", pc, ras_err); end
    call = 1'b1; offset = 5'sd3; tick(); clr_in();
    reset_n = 1'b0; start = 1'b1; start_address = 7'd99; call = 1'b1; offset = 5'sd2; tick(); clr_in();
    total++; if (pc !== 7'd0 || valid !== 1'b0 || done !== 1'b0 || ras_err !== 1'b0) begin bad++; $display("FAIL mid_reset got pc=%0d v=%b d=%b e=%b exp 0/0/0/0", pc, valid, done, ras_err); end
    go(100); ret = 1'b1; tick(); clr_in();
    total++; if (pc !== 7'd101 || ras_err !== 1'b1) begin bad++; $display("FAIL stack_emptied got pc=%0d e=%b exp 101/1", pc, ras_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset_n       = ($urandom_range(79) != 0);
      start         = ($urandom_range(24) == 0);
      start_address = 7'($urandom);
      stall         = ($urandom_range(5) == 0);
      halt          = ($urandom_range(29) == 0);
      ret           = ($urandom_range(4) == 0);
      call          = ($urandom_range(3) == 0);
      branch        = ($urandom_range(2) == 0);
      taken         = 1'($urandom);
      offset        = 5'($urandom);
      tick();
      total++;
      if (pc !== 7'(m_pc) || valid !== (m_st == 1) || done !== (m_st == 2) || ras_err !== 1'(m_err)) begin
        bad++;
        $display("FAIL rand%0d got pc=%0d v=%b d=%b e=%b exp pc=%0d v=%0d d=%0d e=%0d",
                 i, pc, valid, done, ras_err, m_pc, m_st == 1, m_st == 2, m_err);
      end
    end
    clr_in();
  endtask

  initial begin
    clr_in();
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_stall_halt();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
